// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART debug bus master: bus widths, command and
// response bytes, and the parser state encoding.
package uart_bus_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_ACK   = 8'h06;
  localparam logic [BYTE_W-1:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } parser_state_e;

endpackage

// File: rtl/uart_bus_master_if.sv
// PicoRV32-native memory bus between the debug bridge (master) and the
// arbitrated system bus (slave).
//   mem_valid/mem_addr/mem_wdata/mem_wstrb : request, driven by master
//   mem_ready/mem_rdata                     : completion, driven by slave
interface uart_bus_master_if;
  import uart_bus_master_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_bus_master_phy.sv
// Full-duplex 8N1 UART PHY with a fixed bit period of CLK_DIV clocks.
//   rx: ser_rx -> rx_data, rx_valid (1-cycle pulse), rx_frame_err (1-cycle pulse)
//   tx: tx_data/tx_start (accepted when !tx_busy) -> ser_tx, tx_busy
module uart_phy #(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       ser_tx
);

  localparam int unsigned CW   = $clog2(CLK_DIV + 1);
  localparam int unsigned HALF = CLK_DIV / 2;

  logic          rx_act_q, rx_prev_q, rx_valid_q, rx_err_q;
  logic [3:0]    rx_bit_q;
  logic [CW-1:0] rx_cnt_q;
  logic [7:0]    rx_sh_q;
  logic [CW-1:0] rx_lim_c;

  logic          tx_busy_q, ser_tx_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic [8:0]    tx_sh_q;

  // Start bit is checked half a bit in; every later bit one full bit apart.
  assign rx_lim_c = (rx_bit_q == 4'd0) ? CW'(HALF - 1) : CW'(CLK_DIV - 1);

  // Receiver: bit 0 = start, 1..8 = data (LSB first), 9 = stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_act_q   <= 1'b0;
      rx_prev_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_bit_q   <= 4'd0;
      rx_cnt_q   <= '0;
      rx_sh_q    <= 8'h00;
    end else begin
      rx_prev_q  <= ser_rx;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (!rx_act_q) begin
        if (rx_prev_q && !ser_rx) begin
          rx_act_q <= 1'b1;
          rx_bit_q <= 4'd0;
          rx_cnt_q <= '0;
        end
      end else if (rx_cnt_q == rx_lim_c) begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd0) begin
          if (ser_rx) rx_act_q <= 1'b0;  // glitch, not a real start bit
          else        rx_bit_q <= 4'd1;
        end else if (rx_bit_q <= 4'd8) begin
          rx_sh_q  <= {ser_rx, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end else begin
          rx_act_q <= 1'b0;
          if (ser_rx) rx_valid_q <= 1'b1;
          else        rx_err_q   <= 1'b1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + CW'(1);
      end
    end
  end

  // Transmitter: start bit goes out at acceptance, the shifter holds data+stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q <= 1'b0;
      ser_tx_q  <= 1'b1;
      tx_bit_q  <= 4'd0;
      tx_cnt_q  <= '0;
      tx_sh_q   <= 9'h1FF;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q <= 1'b1;
        ser_tx_q  <= 1'b0;
        tx_sh_q   <= {1'b1, tx_data};
        tx_bit_q  <= 4'd0;
        tx_cnt_q  <= '0;
      end
    end else if (tx_cnt_q == CW'(CLK_DIV - 1)) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
      end else begin
        ser_tx_q <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + CW'(1);
    end
  end

  assign rx_data      = rx_sh_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_err_q;
  assign tx_busy      = tx_busy_q;
  assign ser_tx       = ser_tx_q;

endmodule

// File: rtl/uart_bus_master.sv
// UART debug bridge: parses 'W'/'R' commands from ser_rx, runs one bus
// transaction, and answers on ser_tx (ACK for writes, 4 data bytes for reads,
// NAK for unknown commands).
//   clk, reset : clock, synchronous active-high reset
//   ser_rx     : serial command input (8N1, idle high)
//   ser_tx     : serial response output (8N1, idle high)
//   busy       : high whenever the parser is not waiting for a command byte
//   bus        : PicoRV32-native memory bus, master side
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 104,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ser_rx,
  output logic               ser_tx,
  output logic               busy,
  uart_bus_master_if.master  bus
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, tx_busy;
  logic       tx_start_c, timeout_c;
  logic [7:0] tx_data_c;

  parser_state_e     state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]       idle_q, idle_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              nak_pend_q, nak_pend_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk          (clk),
    .reset        (reset),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .tx_data      (tx_data_c),
    .tx_start     (tx_start_c),
    .tx_busy      (tx_busy),
    .ser_tx       (ser_tx)
  );

  assign timeout_c = (idle_q >= 32'(TIMEOUT));

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  // Parser next state; timeout and framing errors take priority over data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) state_d = S_ADDR;
      S_ADDR:
        if (timeout_c || rx_frame_err)        state_d = S_CMD;
        else if (rx_valid && cnt_q == 2'd3)   state_d = is_wr_q ? S_DATA : S_BUS;
      S_DATA:
        if (timeout_c || rx_frame_err)        state_d = S_CMD;
        else if (rx_valid && cnt_q == 2'd3)   state_d = S_BUS;
      S_BUS:
        if (mem_valid_q && bus.mem_ready)     state_d = S_RESP;
      S_RESP:
        if (last_q && !tx_busy)               state_d = S_CMD;
      default:                                state_d = S_CMD;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    idle_d      = 32'd0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    nak_pend_d  = nak_pend_q;
    last_d      = last_q;
    tx_start_c  = 1'b0;
    tx_data_c   = RSP_NAK;
    case (state_q)
      S_CMD: begin
        // NAK is held pending until the TX PHY can take it.
        if (nak_pend_q) begin
          tx_start_c = 1'b1;
          if (!tx_busy) nak_pend_d = 1'b0;
        end
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_wr_d = (rx_data == CMD_WRITE);
            cnt_d   = 2'd0;
          end else begin
            nak_pend_d = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        idle_d = idle_q + 32'd1;
        if (rx_valid && !timeout_c) begin
          idle_d = 32'd0;
          cnt_d  = cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d  = {rx_data, addr_q[31:8]};
          else                   wdata_d = {rx_data, wdata_q[31:8]};
        end
      end
      S_BUS: begin
        if (mem_valid_q && bus.mem_ready) begin
          rdata_d     = bus.mem_rdata;
          mem_valid_d = 1'b0;
          cnt_d       = 2'd0;
          last_d      = 1'b0;
        end
      end
      S_RESP: begin
        tx_data_c  = is_wr_q ? RSP_ACK : rdata_q[{cnt_q, 3'b000} +: 8];
        tx_start_c = !last_q;
        if (!last_q && !tx_busy) begin
          if (is_wr_q || cnt_q == 2'd3) last_d = 1'b1;
          else                          cnt_d  = cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
    // Launch the bus request the cycle after the final command byte.
    if (state_d == S_BUS && state_q != S_BUS) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = {addr_d[31:2], 2'b00};
      mem_wdata_d = wdata_d;
      mem_wstrb_d = is_wr_q ? 4'hF : 4'h0;
    end
    busy_d = (state_d != S_CMD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_wr_q     <= 1'b0;
      cnt_q       <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      idle_q      <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      nak_pend_q  <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      idle_q      <= idle_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      nak_pend_q  <= nak_pend_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART host driver, 3-cycle-latency bus
// slave model, and a serial decoder on ser_tx.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned TIMEOUT = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_rx = 1'b1;
  logic ser_tx, busy;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_bus_master_if bus_if ();

  uart_bus_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_rx (ser_rx),
    .ser_tx (ser_tx),
    .busy   (busy),
    .bus    (bus_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: mem_ready pulses on the 3rd cycle of mem_valid unless held off.
  logic [31:0] mem [logic [31:0]];
  bit          mem_init = 1'b0;
  bit          hold = 1'b0;
  int          bus_cnt = 0;
  int          lat = 0;
  int          ready_cyc = 0;
  bit          vprev = 1'b0;
  bit          stab_err = 1'b0;
  logic [31:0] paddr, pwdata, last_addr, last_wdata;
  logic [3:0]  pstrb, last_wstrb;

  always @(negedge clk) begin
    if (!mem_init) begin
      mem[32'h20] = 32'h12345678;
      mem[32'h40] = 32'hA1B2C3D4;
      mem[32'h44] = 32'h0BADF00D;
      mem_init = 1'b1;
    end
    bus_if.mem_ready = 1'b0;
    if (bus_if.mem_valid === 1'b1) begin
      if (vprev) begin
        if (bus_if.mem_addr !== paddr || bus_if.mem_wdata !== pwdata || bus_if.mem_wstrb !== pstrb)
          stab_err = 1'b1;
      end else begin
        bus_cnt++;
      end
      paddr  = bus_if.mem_addr;
      pwdata = bus_if.mem_wdata;
      pstrb  = bus_if.mem_wstrb;
      if (!hold) begin
        lat++;
        if (lat == 3) begin
          lat = 0;
          bus_if.mem_ready = 1'b1;
          ready_cyc  = cyc;
          last_addr  = bus_if.mem_addr;
          last_wdata = bus_if.mem_wdata;
          last_wstrb = bus_if.mem_wstrb;
          if (bus_if.mem_wstrb == 4'hF) mem[bus_if.mem_addr] = bus_if.mem_wdata;
          bus_if.mem_rdata = mem.exists(bus_if.mem_addr) ? mem[bus_if.mem_addr] : 32'h0;
        end
      end
    end else begin
      lat = 0;
    end
    vprev = (bus_if.mem_valid === 1'b1);
  end

  // Serial decoder on ser_tx: samples each bit at its middle.
  logic [7:0] mon_q [$];
  int         mon_cyc [$];
  logic       tx_prev = 1'b1;
  logic [7:0] mon_b;
  int         mon_st;
  int         tx_stop_err = 0;

  always begin
    @(negedge clk);
    if (tx_prev === 1'b1 && ser_tx === 1'b0) begin
      mon_st = cyc;
      repeat (CLK_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        mon_b[i] = ser_tx;
      end
      repeat (CLK_DIV) @(negedge clk);
      if (ser_tx === 1'b1) begin
        mon_q.push_back(mon_b);
        mon_cyc.push_back(mon_st);
      end else begin
        tx_stop_err++;
      end
    end
    tx_prev = ser_tx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
    if (!stop) repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(mon_q.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (mon_q.size() < i + 4) return 32'hxxxxxxxx;
    return {mon_q[i+3], mon_q[i+2], mon_q[i+1], mon_q[i]};
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int base = mon_q.size();
    send_byte(CMD_READ);
    send_addr(a);
    wait_bytes(base + 4, 1200, {tag, "_wait"});
    chk(tag, word_at(base), exp);
  endtask

  initial begin
    int b0, q0, k;
    int d;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Write 0xDEADBEEF to 0x10
    b0 = bus_cnt;
    q0 = mon_q.size();
    send_byte(CMD_WRITE);
    chk("wr_busy_mid", 32'(busy), 32'd1);
    send_addr(32'h0000_0010);
    send_addr(32'hDEAD_BEEF);
    wait_bytes(q0 + 1, 400, "wr_ack_wait");
    chk("wr_bus_cycles", 32'(bus_cnt - b0), 32'd1);
    chk("wr_addr", last_addr, 32'h0000_0010);
    chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", 32'(last_wstrb), 32'hF);
    chk("wr_ack", 32'(mon_q[q0]), 32'h06);
    chk("wr_ack_after_ready", 32'(mon_cyc[q0] > ready_cyc), 32'd1);
    repeat (20) @(negedge clk);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // Read 0x22 -> word at 0x20, bytes LSB first
    q0 = mon_q.size();
    do_read(32'h0000_0022, 32'h12345678, "rd_word");
    chk("rd_addr", last_addr, 32'h0000_0020);
    chk("rd_wstrb", 32'(last_wstrb), 32'h0);
    chk("rd_byte0", 32'(mon_q[q0]), 32'h78);
    for (int i = 0; i < 3; i++) begin
      d = mon_cyc[q0+i+1] - mon_cyc[q0+i];
      chk("rd_frame_spacing", 32'(d >= 160 && d <= 162), 32'd1);
    end
    repeat (20) @(negedge clk);

    // Unknown command -> NAK, no bus cycle, parser stays idle
    b0 = bus_cnt;
    q0 = mon_q.size();
    send_byte(8'hAA);
    wait_bytes(q0 + 1, 400, "nak_wait");
    chk("nak_byte", 32'(mon_q[q0]), 32'h15);
    chk("nak_no_bus", 32'(bus_cnt - b0), 32'd0);
    chk("nak_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    do_read(32'h0000_0010, 32'hDEADBEEF, "after_nak_read");
    repeat (20) @(negedge clk);

    // Partial write then silence -> timeout, no reply
    b0 = bus_cnt;
    q0 = mon_q.size();
    send_byte(CMD_WRITE);
    send_byte(8'h10);
    send_byte(8'h00);
    chk("to_busy_before", 32'(busy), 32'd1);
    repeat (2500) @(negedge clk);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_no_bus", 32'(bus_cnt - b0), 32'd0);
    chk("to_no_reply", 32'(mon_q.size()), 32'(q0));
    do_read(32'h0000_0020, 32'h12345678, "after_to_read");
    repeat (20) @(negedge clk);

    // Framing error mid-address aborts the command
    b0 = bus_cnt;
    send_byte(CMD_READ);
    send_byte(8'h22);
    chk("fe_busy_before", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0);
    chk("fe_busy_after", 32'(busy), 32'd0);
    chk("fe_no_bus", 32'(bus_cnt - b0), 32'd0);
    do_read(32'h0000_0040, 32'hA1B2C3D4, "after_fe_read");
    repeat (20) @(negedge clk);

    // Reset while a bus request is stalled
    hold = 1'b1;
    send_byte(CMD_READ);
    send_addr(32'h0000_0030);
    k = 0;
    while (bus_if.mem_valid !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("stall_valid", 32'(bus_if.mem_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rst_mid_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    hold = 1'b0;
    repeat (20) @(negedge clk);

    // Back-to-back reads
    do_read(32'h0000_0040, 32'hA1B2C3D4, "b2b_read0");
    do_read(32'h0000_0044, 32'h0BADF00D, "b2b_read1");
    repeat (40) @(negedge clk);

    chk("bus_stable", 32'(stab_err), 32'd0);
    chk("tx_stop_bits", 32'(tx_stop_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
